// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: LED mode controller driving an active-low LED through a PWM.
//
// A free-running PWM counter (cnt1) defines periods of CNT_NUM clocks. Mode
// commands are accepted into a one-deep pending slot and applied on the next
// period end, so a mode change never cuts a PWM period short. Modes: OFF, ON,
// BREATH (duty ramps 0..CNT_NUM..0) and BLINK (full on / full off, each phase
// lasting BLINK_PERIODS periods).
//
// Build option: define LED_MODE_BLINK_EN to include the BLINK mode. Without it,
// the blink counter and blink states are absent and a mode-3 command applies
// as OFF.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   cmd_valid  mode command offered
//   cmd_mode   0=OFF 1=ON 2=BREATH 3=BLINK, sampled on acceptance
//   cmd_ready  command can be accepted this cycle (low while one is pending)
//   cur_mode   currently applied mode, same encoding as cmd_mode
//   duty       current duty, 0..CNT_NUM
//   led        registered LED drive, 0 = lit
module led_mode_ctrl #(
    parameter int CNT_NUM       = 30,
    parameter int BLINK_PERIODS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_mode,
    output logic       cmd_ready,
    output logic [1:0] cur_mode,
    output logic [7:0] duty,
    output logic       led
);

    generate
        if (CNT_NUM < 2 || CNT_NUM > 255)
            $error("CNT_NUM out of range 2..255");
        if (BLINK_PERIODS < 1 || BLINK_PERIODS > 255)
            $error("BLINK_PERIODS out of range 1..255");
    endgenerate

    localparam logic [7:0] TOP  = 8'(CNT_NUM);
    localparam logic [7:0] LAST = 8'(CNT_NUM - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_ON,
        S_UP,
        S_DN
`ifdef LED_MODE_BLINK_EN
        , S_BLK_ON,
        S_BLK_OFF
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt1_q, cnt1_d;
    logic [7:0] duty_q, duty_d;
    logic       led_q, led_d;
    logic       ready_q, ready_d;     // low means a command is pending
    logic [1:0] pmode_q, pmode_d;     // pending command
    logic [1:0] cur_mode_q, cur_mode_d;
`ifdef LED_MODE_BLINK_EN
    localparam logic [7:0] BLK_LAST = 8'(BLINK_PERIODS - 1);
    logic [7:0] blk_cnt_q, blk_cnt_d;
`endif

    logic period_end;

    always_comb begin
        period_end = (cnt1_q == LAST);
        cnt1_d     = period_end ? 8'd0 : cnt1_q + 8'd1;
        led_d      = !(cnt1_q < duty_q);
        state_d    = state_q;
        duty_d     = duty_q;
        ready_d    = ready_q;
        pmode_d    = pmode_q;
`ifdef LED_MODE_BLINK_EN
        blk_cnt_d  = blk_cnt_q;
`endif

        // Acceptance needs ready_q=1 and apply needs ready_q=0, so the two
        // never coincide; a command accepted on a period end waits a period.
        if (cmd_valid && ready_q) begin
            ready_d = 1'b0;
            pmode_d = cmd_mode;
        end

        if (period_end) begin
            if (!ready_q) begin
                // Apply wins over the in-mode update on the same period end.
                ready_d = 1'b1;
                case (pmode_q)
                    2'd1: begin state_d = S_ON; duty_d = TOP;  end
                    2'd2: begin state_d = S_UP; duty_d = 8'd0; end
`ifdef LED_MODE_BLINK_EN
                    2'd3: begin
                        state_d   = S_BLK_ON;
                        duty_d    = TOP;
                        blk_cnt_d = 8'd0;
                    end
`endif
                    default: begin state_d = S_OFF; duty_d = 8'd0; end
                endcase
            end else begin
                case (state_q)
                    S_UP: begin
                        if (duty_q < TOP) duty_d  = duty_q + 8'd1;
                        else              state_d = S_DN;
                    end
                    S_DN: begin
                        if (duty_q != 8'd0) duty_d  = duty_q - 8'd1;
                        else                state_d = S_UP;
                    end
`ifdef LED_MODE_BLINK_EN
                    S_BLK_ON, S_BLK_OFF: begin
                        if (blk_cnt_q == BLK_LAST) begin
                            blk_cnt_d = 8'd0;
                            state_d   = (state_q == S_BLK_ON) ? S_BLK_OFF : S_BLK_ON;
                            duty_d    = (state_q == S_BLK_ON) ? 8'd0 : TOP;
                        end else begin
                            blk_cnt_d = blk_cnt_q + 8'd1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end

        case (state_d)
            S_ON:       cur_mode_d = 2'd1;
            S_UP, S_DN: cur_mode_d = 2'd2;
`ifdef LED_MODE_BLINK_EN
            S_BLK_ON, S_BLK_OFF: cur_mode_d = 2'd3;
`endif
            default:    cur_mode_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_OFF;
            cnt1_q     <= 8'd0;
            duty_q     <= 8'd0;
            led_q      <= 1'b1;
            ready_q    <= 1'b1;
            pmode_q    <= 2'd0;
            cur_mode_q <= 2'd0;
`ifdef LED_MODE_BLINK_EN
            blk_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt1_q     <= cnt1_d;
            duty_q     <= duty_d;
            led_q      <= led_d;
            ready_q    <= ready_d;
            pmode_q    <= pmode_d;
            cur_mode_q <= cur_mode_d;
`ifdef LED_MODE_BLINK_EN
            blk_cnt_q  <= blk_cnt_d;
`endif
        end
    end

    assign cmd_ready = ready_q;
    assign cur_mode  = cur_mode_q;
    assign duty      = duty_q;
    assign led       = led_q;

endmodule
